// File: rtl/grp_scheduler_n_pkg.sv
// Shared types and default parameters for the grouped LS/BS WQE scheduler.
package grp_scheduler_n_pkg;

  localparam int unsigned WQE_WIDTH_DEF       = 512;
  localparam int unsigned SLOT_NUM_DEF        = 8;
  localparam int unsigned SLOT_ADDR_WIDTH_DEF = 3;
  localparam int unsigned WT_WIDTH_DEF        = 5;
  localparam int unsigned LS_BURST_MAX_DEF    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } sched_state_e;

  typedef enum logic {
    WQE_LS = 1'b0,
    WQE_BS = 1'b1
  } wqe_type_e;

endpackage

// File: rtl/wrr_credit_arbiter.sv
// Credit-based weighted round-robin over the BS station-buffer slots.
module wrr_credit_arbiter
  import grp_scheduler_n_pkg::*;
#(
  parameter int unsigned SLOT_NUM = SLOT_NUM_DEF,
  parameter int unsigned WT_WIDTH = WT_WIDTH_DEF,
  localparam int unsigned IDX_W   = $clog2(SLOT_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SLOT_NUM-1:0]          req_i,
  input  logic                         req_val_i,
  input  logic [SLOT_NUM*WT_WIDTH-1:0] wt_cfg_i,
  input  logic                         load_i,
  output logic                         gnt_val_o,
  output logic [IDX_W-1:0]             gnt_idx_o
);

  logic [WT_WIDTH-1:0] eff_wt    [SLOT_NUM];
  logic [WT_WIDTH-1:0] base_cred [SLOT_NUM];
  logic [WT_WIDTH-1:0] cred_q    [SLOT_NUM];
  logic [WT_WIDTH-1:0] cred_d    [SLOT_NUM];
  logic [IDX_W-1:0]    ptr_q, ptr_d, base_ptr, hit_idx, rl_idx, jj;
  logic                hit, rl_hit;
  int unsigned         j;

  // A load in the grant cycle makes the grant see the fresh credits and pointer.
  always_comb begin
    for (int unsigned k = 0; k < SLOT_NUM; k++) begin
      eff_wt[k]    = (wt_cfg_i[k*WT_WIDTH +: WT_WIDTH] == '0) ? WT_WIDTH'(1)
                                                              : wt_cfg_i[k*WT_WIDTH +: WT_WIDTH];
      base_cred[k] = load_i ? eff_wt[k] : cred_q[k];
    end
  end

  always_comb begin
    hit      = 1'b0;
    rl_hit   = 1'b0;
    hit_idx  = '0;
    rl_idx   = '0;
    j        = 0;
    jj       = '0;
    base_ptr = load_i ? '0 : ptr_q;
    for (int unsigned i = 0; i < SLOT_NUM; i++) begin
      j = 32'(base_ptr) + i;
      if (j >= SLOT_NUM) j = j - SLOT_NUM;
      jj = IDX_W'(j);
      if (!hit && req_i[jj] && (base_cred[jj] != '0)) begin
        hit     = 1'b1;
        hit_idx = jj;
      end
      if (!rl_hit && req_i[jj]) begin
        rl_hit = 1'b1;
        rl_idx = jj;
      end
    end
  end

  assign gnt_val_o = req_val_i & (|req_i);
  assign gnt_idx_o = hit ? hit_idx : rl_idx;

  // With no creditable requester, credits reload and the first requester wins.
  always_comb begin
    cred_d = cred_q;
    ptr_d  = ptr_q;
    if (gnt_val_o) begin
      for (int unsigned k = 0; k < SLOT_NUM; k++)
        cred_d[k] = hit ? base_cred[k] : eff_wt[k];
      cred_d[gnt_idx_o] = cred_d[gnt_idx_o] - WT_WIDTH'(1);
      ptr_d = (32'(gnt_idx_o) == SLOT_NUM - 1) ? '0 : gnt_idx_o + IDX_W'(1);
    end else if (load_i) begin
      cred_d = eff_wt;
      ptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q <= eff_wt;
      ptr_q  <= '0;
    end else begin
      cred_q <= cred_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: rtl/grp_scheduler_n.sv
// Grouped WQE scheduler: LS strict priority with burst limit, BS slots by credit WRR.
module grp_scheduler_n
  import grp_scheduler_n_pkg::*;
#(
  parameter int unsigned WQE_WIDTH       = WQE_WIDTH_DEF,
  parameter int unsigned SLOT_NUM        = SLOT_NUM_DEF,
  parameter int unsigned SLOT_ADDR_WIDTH = SLOT_ADDR_WIDTH_DEF,
  parameter int unsigned WT_WIDTH        = WT_WIDTH_DEF,
  parameter int unsigned LS_BURST_MAX    = LS_BURST_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_ls_wqe_empty,
  output logic                         o_ls_wqe_ren,
  input  logic [WQE_WIDTH-1:0]         i_ls_wqe_rdata,
  output logic                         o_ren,
  output logic                         o_wen,
  output logic [SLOT_ADDR_WIDTH-1:0]   o_addr,
  output logic [WQE_WIDTH-1:0]         o_din,
  input  logic [WQE_WIDTH-1:0]         i_dout,
  input  logic [SLOT_NUM-1:0]          i_slot_status,
  input  logic [SLOT_NUM*WT_WIDTH-1:0] i_wt_cfg,
  input  logic                         i_wt_load,
  output logic                         o_wqe_cache_empty,
  input  logic                         i_wqe_cache_rd,
  output logic                         o_wqe_val,
  output logic                         o_wqe_type,
  output logic [SLOT_ADDR_WIDTH-1:0]   o_wqe_addr,
  output logic [WQE_WIDTH-1:0]         o_wqe,
  input  logic                         i_pwqe_wb,
  input  logic [SLOT_ADDR_WIDTH-1:0]   i_pwqe_addr,
  input  logic [WQE_WIDTH-1:0]         i_pwqe
);

  sched_state_e               state_q;
  logic [3:0]                 burst_q;
  logic                       any_slot, work, grant, grant_bs, grant_ls, arb_gnt;
  logic [SLOT_ADDR_WIDTH-1:0] arb_idx;
  logic                       s1_val_q, wqe_val_q;
  wqe_type_e                  s1_type_q, wqe_type_q;
  logic [SLOT_ADDR_WIDTH-1:0] s1_addr_q, wqe_addr_q, addr_q, pend_addr_q, wr_addr;
  logic                       ls_ren_q, ren_q, wen_q, pend_q, wr_avail;
  logic [WQE_WIDTH-1:0]       din_q, pend_data_q, wr_data;

  assign any_slot          = |i_slot_status;
  assign work              = ~i_ls_wqe_empty | any_slot;
  assign o_wqe_cache_empty = i_ls_wqe_empty & ~any_slot;
  assign grant             = work & ((state_q == ST_IDLE) ? i_wqe_cache_rd : 1'b1);
  assign grant_bs          = grant & any_slot & (i_ls_wqe_empty | (burst_q == 4'(LS_BURST_MAX)));
  assign grant_ls          = grant & ~grant_bs;

  wrr_credit_arbiter #(
    .SLOT_NUM (SLOT_NUM),
    .WT_WIDTH (WT_WIDTH)
  ) u_wrr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (i_slot_status),
    .req_val_i (grant_bs),
    .wt_cfg_i  (i_wt_cfg),
    .load_i    (i_wt_load),
    .gnt_val_o (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // A pending write-back takes precedence over a new request on the same port.
  assign wr_avail = pend_q | i_pwqe_wb;
  assign wr_addr  = pend_q ? pend_addr_q : i_pwqe_addr;
  assign wr_data  = pend_q ? pend_data_q : i_pwqe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_q     <= '0;
      s1_val_q    <= 1'b0;
      s1_type_q   <= WQE_LS;
      s1_addr_q   <= '0;
      wqe_val_q   <= 1'b0;
      wqe_type_q  <= WQE_LS;
      wqe_addr_q  <= '0;
      ls_ren_q    <= 1'b0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_wqe_cache_rd && !work) state_q <= ST_WAIT;
        ST_WAIT: if (work) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (arb_gnt || !any_slot)
        burst_q <= '0;
      else if (grant_ls && (burst_q != 4'(LS_BURST_MAX)))
        burst_q <= burst_q + 4'd1;

      s1_val_q  <= grant;
      s1_type_q <= arb_gnt ? WQE_BS : WQE_LS;
      s1_addr_q <= arb_idx;
      wqe_val_q <= s1_val_q;
      if (s1_val_q) begin
        wqe_type_q <= s1_type_q;
        wqe_addr_q <= (s1_type_q == WQE_BS) ? s1_addr_q : '0;
      end

      ls_ren_q <= grant_ls;
      ren_q    <= arb_gnt;
      if (arb_gnt) begin
        wen_q       <= 1'b0;
        addr_q      <= arb_idx;
        din_q       <= '0;
        pend_q      <= wr_avail;
        pend_addr_q <= wr_addr;
        pend_data_q <= wr_data;
      end else begin
        wen_q  <= wr_avail;
        addr_q <= wr_avail ? wr_addr : '0;
        din_q  <= wr_avail ? wr_data : '0;
        pend_q <= 1'b0;
      end
    end
  end

  assign o_ls_wqe_ren = ls_ren_q;
  assign o_ren        = ren_q;
  assign o_wen        = wen_q;
  assign o_addr       = addr_q;
  assign o_din        = din_q;
  assign o_wqe_val    = wqe_val_q;
  assign o_wqe_type   = wqe_type_q;
  assign o_wqe_addr   = wqe_addr_q;
  assign o_wqe        = !wqe_val_q ? '0 : (wqe_type_q == WQE_BS) ? i_dout : i_ls_wqe_rdata;

endmodule

// File: tb/tb_grp_scheduler_n.sv
// Scoreboard bench for grp_scheduler_n against a transaction-level reference model.
module tb_grp_scheduler_n;

  localparam int W    = 512;
  localparam int N    = 8;
  localparam int AW   = 3;
  localparam int WW   = 5;
  localparam int BMAX = 4;

  logic            clk, rst;
  logic            ls_empty, rd, wt_load, wb;
  logic [N-1:0]    slot_status;
  logic [N*WW-1:0] wt_cfg;
  logic [AW-1:0]   wb_addr;
  logic [W-1:0]    wb_data, ls_rdata, dout;
  logic            o_ls_wqe_ren, o_ren, o_wen, o_wqe_cache_empty, o_wqe_val, o_wqe_type;
  logic [AW-1:0]   o_addr, o_wqe_addr;
  logic [W-1:0]    o_din, o_wqe;

  grp_scheduler_n #(
    .WQE_WIDTH(W), .SLOT_NUM(N), .SLOT_ADDR_WIDTH(AW), .WT_WIDTH(WW), .LS_BURST_MAX(BMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ls_wqe_empty(ls_empty), .o_ls_wqe_ren(o_ls_wqe_ren), .i_ls_wqe_rdata(ls_rdata),
    .o_ren(o_ren), .o_wen(o_wen), .o_addr(o_addr), .o_din(o_din), .i_dout(dout),
    .i_slot_status(slot_status), .i_wt_cfg(wt_cfg), .i_wt_load(wt_load),
    .o_wqe_cache_empty(o_wqe_cache_empty), .i_wqe_cache_rd(rd),
    .o_wqe_val(o_wqe_val), .o_wqe_type(o_wqe_type), .o_wqe_addr(o_wqe_addr), .o_wqe(o_wqe),
    .i_pwqe_wb(wb), .i_pwqe_addr(wb_addr), .i_pwqe(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ls_word(input int n);
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) r[k*32 +: 32] = 32'(n) * 32'h9E3779B1 + 32'(k);
    return r;
  endfunction

  function automatic logic [W-1:0] mem_init(input int s);
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) r[k*32 +: 32] = 32'hA000_0000 + 32'(s) * 32'h1111 + 32'(k);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Effective weight: a programmed 0 counts as 1.
  function automatic int wt_of(input int s);
    int w;
    w = int'(wt_cfg[s*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  // External LS FIFO and station buffer, both with one-cycle read latency.
  logic [W-1:0] mem [N];
  int           fifo_n = 0;
  always @(posedge clk) begin
    if (o_ls_wqe_ren) begin
      ls_rdata <= ls_word(fifo_n);
      fifo_n   <= fifo_n + 1;
    end
    if (rst) begin
      for (int s = 0; s < N; s++) mem[s] <= mem_init(s);
    end else begin
      if (o_ren) dout <= mem[o_addr];
      if (o_wen) mem[o_addr] <= o_din;
    end
  end

  typedef struct { logic typ; logic [AW-1:0] addr; logic [W-1:0] data; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
  exp_t exp_q [$];
  wr_t  m_wq  [$];

  bit           m_wait;
  int           m_burst, m_ptr, m_ls_n;
  int           m_cred [N];
  logic [W-1:0] m_mem  [N];
  logic         obs_type [$];
  int           obs_slot_cnt [N];
  int           obs_val_n;

  // One clock of stimulus: the model predicts this cycle's decisions, then the edge is checked.
  task automatic step();
    bit           e_ls, e_bs, e_wen, work, grant;
    int           idx, p;
    int           base [N];
    logic [AW-1:0] e_addr;
    logic [W-1:0]  e_din;
    e_ls = 0; e_bs = 0; e_wen = 0; e_addr = '0; e_din = '0; idx = -1;
    if (rst) begin
      m_wait = 0; m_burst = 0; m_ptr = 0;
      for (int s = 0; s < N; s++) begin
        m_cred[s] = wt_of(s);
        m_mem[s]  = mem_init(s);
      end
      m_wq.delete();
      exp_q.delete();
    end else begin
      work  = !ls_empty || (slot_status != 0);
      grant = work && (m_wait || rd);
      if (!m_wait && rd && !work) m_wait = 1;
      else if (m_wait && work)    m_wait = 0;
      e_bs = grant && (slot_status != 0) && (ls_empty || m_burst == BMAX);
      e_ls = grant && !e_bs;
      if (e_bs) begin
        for (int s = 0; s < N; s++) base[s] = wt_load ? wt_of(s) : m_cred[s];
        p = wt_load ? 0 : m_ptr;
        for (int i = 0; i < N; i++)
          if (idx < 0 && slot_status[(p+i)%N] && base[(p+i)%N] > 0) idx = (p+i)%N;
        if (idx < 0) begin
          for (int s = 0; s < N; s++) base[s] = wt_of(s);
          for (int i = 0; i < N; i++)
            if (idx < 0 && slot_status[(p+i)%N]) idx = (p+i)%N;
        end
        m_cred = base;
        m_cred[idx]--;
        m_ptr = (idx + 1) % N;
      end else if (wt_load) begin
        for (int s = 0; s < N; s++) m_cred[s] = wt_of(s);
        m_ptr = 0;
      end
      if (e_bs || slot_status == 0) m_burst = 0;
      else if (e_ls && m_burst < BMAX) m_burst++;
      if (e_bs) exp_q.push_back('{1'b1, AW'(idx), m_mem[idx]});
      if (e_ls) begin
        exp_q.push_back('{1'b0, '0, ls_word(m_ls_n)});
        m_ls_n++;
      end
      if (wb) m_wq.push_back('{wb_addr, wb_data});
      if (!e_bs && m_wq.size() > 0) begin
        wr_t w;
        w = m_wq.pop_front();
        e_wen = 1; e_addr = w.addr; e_din = w.data;
        m_mem[w.addr] = w.data;
      end
      if (e_bs) e_addr = AW'(idx);
    end
    @(posedge clk); #1;
    chk("ls_ren", o_ls_wqe_ren, e_ls);
    chk("ren",    o_ren,        e_bs);
    chk("wen",    o_wen,        e_wen);
    chk("addr",   o_addr,       e_addr);
    chk("din",    o_din,        e_din);
    if (rst) begin
      chk("rst_wqe_val",  o_wqe_val,  0);
      chk("rst_wqe_type", o_wqe_type, 0);
      chk("rst_wqe_addr", o_wqe_addr, 0);
      chk("rst_wqe",      o_wqe,      0);
    end
    rd = 0; wt_load = 0; wb = 0;
  endtask

  task automatic drain(input int n);
    slot_status = '0; ls_empty = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a WQE.
  initial begin
    exp_t e;
    obs_val_n = 0;
    forever begin
      @(negedge clk);
      chk("ren_wen_exclusive", o_ren & o_wen, 0);
      if (o_wqe_val) begin
        obs_val_n++;
        obs_type.push_back(o_wqe_type);
        if (o_wqe_type) obs_slot_cnt[o_wqe_addr]++;
        if (exp_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL spurious_wqe_val: got o_wqe_val=1 expected 0");
        end else begin
          e = exp_q.pop_front();
          chk("wqe_type", o_wqe_type, e.typ);
          chk("wqe_addr", o_wqe_addr, e.addr);
          chk("wqe_data", o_wqe,      e.data);
        end
      end
    end
  end

  initial begin
    int           seq [10];
    int           vbefore;
    logic [W-1:0] empty_act;
    seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rst = 1; ls_empty = 1; slot_status = '0; rd = 0; wt_load = 0; wb = 0;
    wb_addr = '0; wb_data = '0; m_ls_n = 0;
    for (int s = 0; s < N; s++) wt_cfg[s*WW +: WW] = WW'(s + 1);
    step(); step();
    rst = 0;
    empty_act = W'(o_wqe_cache_empty);
    chk("cache_empty_idle", empty_act, 1);

    // LS only: ren at T+1, LS data at T+2
    ls_empty = 0; rd = 1; #1;
    chk("cache_empty_ls", W'(o_wqe_cache_empty), 0);
    step(); step(); step();
    drain(2);

    // Weights 8/4 on slots 0/1, 24 back-to-back reads
    wt_cfg = '0;
    wt_cfg[0 +: WW] = WW'(8);
    wt_cfg[WW +: WW] = WW'(4);
    rst = 1; step(); rst = 0;
    for (int s = 0; s < N; s++) obs_slot_cnt[s] = 0;
    slot_status = 8'b0000_0011;
    for (int i = 0; i < 24; i++) begin rd = 1; step(); end
    drain(3);
    chk("wrr_slot0_count", obs_slot_cnt[0], 16);
    chk("wrr_slot1_count", obs_slot_cnt[1], 8);

    // LS burst limit with slot 3 waiting
    obs_type.delete();
    ls_empty = 0; slot_status = 8'b0000_1000;
    for (int i = 0; i < 10; i++) begin rd = 1; step(); end
    drain(3);
    chk("burst_len", obs_type.size(), 10);
    for (int i = 0; i < 10 && i < obs_type.size(); i++) chk("burst_seq", obs_type[i], seq[i]);

    // Read with nothing available waits, then slot 5 appears
    rd = 1; step(); step(); step(); step();
    slot_status = 8'b0010_0000; step(); step(); step();
    drain(2);

    // Write-back colliding with a BS read of slot 6, then read slot 2 back
    slot_status = 8'b0100_0000; rd = 1;
    wb = 1; wb_addr = 3'd2; wb_data = rand_word();
    step(); step(); step();
    slot_status = 8'b0000_0100; rd = 1; step(); step(); step();
    drain(2);

    // Reset while a grant is in flight drops it
    ls_empty = 0; rd = 1; step();
    vbefore = obs_val_n;
    rst = 1; step(); rst = 0;
    drain(3);
    chk("rst_drops_grant", obs_val_n, vbefore);

    // Weight 0 behaves as 1, load coincident with a grant
    for (int s = 0; s < N; s++) begin obs_slot_cnt[s] = 0; wt_cfg[s*WW +: WW] = WW'(3); end
    wt_cfg[4*WW +: WW] = '0;
    wt_cfg[5*WW +: WW] = WW'(2);
    slot_status = 8'b0011_0000; ls_empty = 1; wt_load = 1;
    for (int i = 0; i < 6; i++) begin rd = 1; step(); end
    drain(3);
    chk("wt0_slot4_count", obs_slot_cnt[4], 2);
    chk("wt0_slot5_count", obs_slot_cnt[5], 4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rd          = ($urandom_range(0, 2) != 0);
      ls_empty    = ($urandom_range(0, 2) == 0);
      slot_status = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      if (m_wq.size() == 0 && $urandom_range(0, 5) == 0) begin
        wb = 1; wb_addr = AW'($urandom); wb_data = rand_word();
      end
      if ($urandom_range(0, 40) == 0) begin
        for (int s = 0; s < N; s++) wt_cfg[s*WW +: WW] = WW'($urandom_range(0, 6));
        wt_load = ($urandom_range(0, 1) == 1);
      end
      step();
    end
    drain(4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
